// File: rtl/fp_adder_arbiter.sv
// Round-robin arbiter that shares one pipelined FP adder between NUM_REQ
// requesters. The winning operand pair is registered into the adder, and a
// tag pipeline matched to ADD_LAT steers each result back to its requester.
module fp_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADD_LAT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic                        hold,
    output logic [DATA_W-1:0]           add_a,
    output logic [DATA_W-1:0]           add_b,
    output logic                        add_valid,
    input  logic [DATA_W-1:0]           add_result,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        busy,
    output logic [$clog2(ADD_LAT+2)-1:0] outstanding
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int OUT_W = $clog2(ADD_LAT + 2);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  winner;
    logic              found;
    logic              grant;
    logic [PTR_W-1:0]  issue_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              resp_fire;

    logic              tag_v  [ADD_LAT];
    logic [PTR_W-1:0]  tag_id [ADD_LAT];

    // Round-robin search starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    assign grant = found & ~hold & ~rst;

    // One-hot ready to the winner; hold and reset block the grant immediately
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a = req_a[int'(winner)*DATA_W +: DATA_W];
        sel_b = req_b[int'(winner)*DATA_W +: DATA_W];
    end

    // Issue register: capture winner operands and advance the pointer past it
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_valid <= 1'b0;
            issue_id  <= '0;
        end else if (grant) begin
            add_a     <= sel_a;
            add_b     <= sel_b;
            add_valid <= 1'b1;
            issue_id  <= winner;
            ptr       <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end else begin
            add_valid <= 1'b0;
        end
    end

    // Tag pipeline tracking requester id alongside the adder latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= add_valid;
            tag_id[0] <= issue_id;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign resp_fire = tag_v[ADD_LAT-1];
    assign resp_data = add_result;

    // Steer the emerging result to its originating requester
    always_comb begin
        resp_valid = '0;
        if (resp_fire && !rst) begin
            resp_valid[tag_id[ADD_LAT-1]] = 1'b1;
        end
    end

    // Busy while anything sits in the issue register or the tag pipeline
    always_comb begin
        logic any_v;
        any_v = add_valid;
        for (int k = 0; k < ADD_LAT; k++) begin
            any_v = any_v | tag_v[k];
        end
        busy = any_v & ~rst;
    end

    // Outstanding count: +1 on issue, -1 on return, both cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({grant, resp_fire})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
